// File: rtl/mdio_pkg.sv
// MDIO management-frame definitions shared by the controller,
// its clock generator and the interface.
package mdio_pkg;

    localparam int FRAME_BITS = 32;
    localparam int RD_SPLIT   = 16;
    localparam int PRE_BITS   = 32;

    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam int ST_HI  = 31;
    localparam int ST_LO  = 30;
    localparam int OP_HI  = 29;
    localparam int OP_LO  = 28;
    localparam int PHY_HI = 27;
    localparam int PHY_LO = 23;
    localparam int REG_HI = 22;
    localparam int REG_LO = 18;
    localparam int TA_HI  = 17;
    localparam int TA_LO  = 16;
    localparam int DAT_HI = 15;
    localparam int DAT_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SEND,
        S_RD_CAPTURE,
        S_DONE
    } state_t;

    function automatic logic is_read_op(input logic [FRAME_BITS-1:0] frame);
        return frame[OP_HI:OP_LO] == OP_READ;
    endfunction

endpackage

// File: rtl/mdio_if.sv
// Request, serial-line and status signals of one MDIO station.
// The controller is the master; the PHY side / requester is the slave.
interface mdio_if;
    import mdio_pkg::*;

    logic [FRAME_BITS-1:0] T_DATA;
    logic                  T_VALID;
    logic                  MDIO_IN;
    logic                  MDC;
    logic                  MDIO_OUT;
    logic                  MDIO_OE;
    logic [15:0]           RD_DATA;
    logic                  DATA_RDY;
    logic                  BUSY;

    modport master (
        input  T_DATA, T_VALID, MDIO_IN,
        output MDC, MDIO_OUT, MDIO_OE, RD_DATA, DATA_RDY, BUSY
    );

    modport slave (
        output T_DATA, T_VALID, MDIO_IN,
        input  MDC, MDIO_OUT, MDIO_OE, RD_DATA, DATA_RDY, BUSY
    );

endinterface

// File: rtl/mdio_mdc_gen.sv
// MDC divider: toggles MDC every CLK_DIV clk while enabled and
// flags the clk on which MDC rises or falls.
module mdc_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic mdc,
    output logic mdc_rise,
    output logic mdc_fall
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          mdc_q, mdc_d;
    logic          tick;

    // Count half-periods; an idle divider is held cleared with MDC low.
    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = cnt_q + CW'(1);
        mdc_d = mdc_q;
        if (!en) begin
            cnt_d = '0;
            mdc_d = 1'b0;
        end else if (tick) begin
            cnt_d = '0;
            mdc_d = ~mdc_q;
        end
    end

    // Divider state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

    assign mdc      = mdc_q;
    assign mdc_rise = tick && !mdc_q;
    assign mdc_fall = tick &&  mdc_q;

endmodule

// File: rtl/mdio_controller.sv
// MDIO station-management initiator: serialises one 32-bit frame per
// request and, for reads, turns the line around and captures 16 bits.
module mdio_controller
    import mdio_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter bit PRE_EN  = 1'b0
) (
    input  logic  clk,
    input  logic  reset,
    mdio_if.master bus
);

    localparam logic [4:0] LAST_PRE  = 5'(PRE_BITS - 1);
    localparam logic [4:0] LAST_BIT  = 5'(FRAME_BITS - 1);
    localparam logic [4:0] SPLIT_BIT = 5'(RD_SPLIT - 1);
    localparam logic [4:0] CAP_LAST  = 5'(FRAME_BITS - RD_SPLIT - 1);

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [15:0]           rx_shift_q, rx_shift_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic                  is_rd_q, is_rd_d;
    logic                  out_q, out_d;
    logic                  oe_q, oe_d;
    logic [15:0]           rd_data_q, rd_data_d;
    logic                  rdy_q, rdy_d;

    logic run;
    logic mdc;
    logic mdc_rise;
    logic mdc_fall;

    assign run = (state_q == S_PREAMBLE) ||
                 (state_q == S_SEND) ||
                 (state_q == S_RD_CAPTURE);

    mdc_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_mdc_gen (
        .clk      (clk),
        .reset    (reset),
        .en       (run),
        .mdc      (mdc),
        .mdc_rise (mdc_rise),
        .mdc_fall (mdc_fall)
    );

    // Frame sequencer: line changes happen on MDC falls, capture on rises.
    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        is_rd_d    = is_rd_q;
        out_d      = out_q;
        oe_d       = oe_q;
        rd_data_d  = rd_data_q;
        rdy_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.T_VALID) begin
                    state_d    = PRE_EN ? S_PREAMBLE : S_SEND;
                    tx_shift_d = bus.T_DATA;
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                    is_rd_d    = is_read_op(bus.T_DATA);
                    out_d      = PRE_EN ? 1'b1 : bus.T_DATA[FRAME_BITS-1];
                    oe_d       = 1'b1;
                end
            end
            S_PREAMBLE: begin
                if (mdc_fall) begin
                    if (bit_cnt_q == LAST_PRE) begin
                        state_d   = S_SEND;
                        bit_cnt_d = '0;
                        out_d     = tx_shift_q[FRAME_BITS-1];
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            S_SEND: begin
                if (mdc_fall) begin
                    if (is_rd_q && (bit_cnt_q == SPLIT_BIT)) begin
                        state_d   = S_RD_CAPTURE;
                        bit_cnt_d = '0;
                        out_d     = 1'b0;
                        oe_d      = 1'b0;
                    end else if (bit_cnt_q == LAST_BIT) begin
                        state_d = S_DONE;
                        out_d   = 1'b0;
                        oe_d    = 1'b0;
                    end else begin
                        bit_cnt_d  = bit_cnt_q + 5'd1;
                        tx_shift_d = {tx_shift_q[FRAME_BITS-2:0], 1'b0};
                        out_d      = tx_shift_q[FRAME_BITS-2];
                    end
                end
            end
            S_RD_CAPTURE: begin
                if (mdc_rise) begin
                    rx_shift_d = {rx_shift_q[14:0], bus.MDIO_IN};
                end
                if (mdc_fall) begin
                    if (bit_cnt_q == CAP_LAST) begin
                        state_d   = S_DONE;
                        rd_data_d = rx_shift_q;
                        rdy_d     = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer and output registers; reset aborts any frame at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            is_rd_q    <= 1'b0;
            out_q      <= 1'b0;
            oe_q       <= 1'b0;
            rd_data_q  <= '0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
            is_rd_q    <= is_rd_d;
            out_q      <= out_d;
            oe_q       <= oe_d;
            rd_data_q  <= rd_data_d;
            rdy_q      <= rdy_d;
        end
    end

    assign bus.MDC      = mdc;
    assign bus.MDIO_OUT = out_q;
    assign bus.MDIO_OE  = oe_q;
    assign bus.RD_DATA  = rd_data_q;
    assign bus.DATA_RDY = rdy_q;
    assign bus.BUSY     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mdio_controller.sv
// Bench for mdio_controller: two instances (CLK_DIV=2 no preamble,
// CLK_DIV=1 with preamble) driven by a wire-level PHY register model.
module tb_mdio_controller;
    import mdio_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] t_data;
    logic        tv0, tv1;
    logic        mdio_in;
    int          sel;

    logic        m_mdc, m_out, m_oe, m_rdy, m_busy;
    logic [15:0] m_rd;

    logic [15:0] ref_regs [1024];
    logic [15:0] phy_regs [1024];
    logic [15:0] rd_last  [2];

    int n_checks;
    int n_errors;

    mdio_if if0 ();
    mdio_if if1 ();

    assign if0.T_DATA  = t_data;
    assign if0.T_VALID = tv0;
    assign if0.MDIO_IN = mdio_in;
    assign if1.T_DATA  = t_data;
    assign if1.T_VALID = tv1;
    assign if1.MDIO_IN = mdio_in;

    mdio_controller #(.CLK_DIV(2), .PRE_EN(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    mdio_controller #(.CLK_DIV(1), .PRE_EN(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe whichever instance is under test.
    always_comb begin
        if (sel == 0) begin
            m_mdc  = if0.MDC;
            m_out  = if0.MDIO_OUT;
            m_oe   = if0.MDIO_OE;
            m_rdy  = if0.DATA_RDY;
            m_busy = if0.BUSY;
            m_rd   = if0.RD_DATA;
        end else begin
            m_mdc  = if1.MDC;
            m_out  = if1.MDIO_OUT;
            m_oe   = if1.MDIO_OE;
            m_rdy  = if1.DATA_RDY;
            m_busy = if1.BUSY;
            m_rd   = if1.RD_DATA;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One request on unit u. inj: 1 = stray T_VALID mid-frame,
    // 2 = stray T_VALID in the last busy clk. abort_at >= 0: reset
    // right after that frame bit is sampled by the PHY.
    task automatic run_frame(input int u, input logic [31:0] frame,
                             input int inj, input int abort_at);
        int          cd, p, explat, edges, rises, e0, e1;
        int          rdy_cnt, inj_edge, r, n;
        logic [63:0] obs_out, obs_oe, exp_out, exp_oe;
        logic [31:0] wf;
        logic [15:0] phy_word, exp_rd, rd_at;
        logic [9:0]  idx, widx;
        logic        prev_mdc, rd_op, aborted, inj_on, done;
        cd      = (u != 0) ? 1 : 2;
        p       = (u != 0) ? PRE_BITS : 0;
        explat  = (p + FRAME_BITS) * 2 * cd + 2;
        rd_op   = frame[OP_HI:OP_LO] == OP_READ;
        idx     = frame[PHY_HI:REG_LO];
        exp_rd  = ref_regs[idx];
        exp_out = '0;
        exp_oe  = '0;
        for (int i = 0; i < p + FRAME_BITS; i++) begin
            if (i < p) begin
                exp_out[i] = 1'b1;
                exp_oe[i]  = 1'b1;
            end else if (!(rd_op && (i - p) >= RD_SPLIT)) begin
                exp_out[i] = frame[31 - (i - p)];
                exp_oe[i]  = 1'b1;
            end
        end
        inj_edge = (inj == 1) ? 40 : ((inj == 2) ? explat - 1 : -1);
        edges = 0; rises = 0; e0 = 0; e1 = 0; rdy_cnt = 0;
        obs_out = '0; obs_oe = '0; wf = '0; rd_at = '0;
        phy_word = 16'($urandom);
        prev_mdc = 1'b0; aborted = 1'b0; inj_on = 1'b0; done = 1'b0;
        sel = u;
        mdio_in = 1'($urandom);
        @(negedge clk);
        t_data = frame;
        if (u == 0) tv0 = 1'b1; else tv1 = 1'b1;
        while (!done) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1 || inj_on) begin
                tv0 = 1'b0; tv1 = 1'b0; inj_on = 1'b0;
            end
            if (edges == inj_edge) begin
                t_data = 32'h5000_1234;
                if (u == 0) tv0 = 1'b1; else tv1 = 1'b1;
                inj_on = 1'b1;
            end
            if (m_rdy) begin
                if (rdy_cnt == 0) rd_at = m_rd;
                rdy_cnt++;
            end
            if (m_mdc && !prev_mdc) begin
                r = rises;
                if (r < 64) begin
                    obs_out[r] = m_out;
                    obs_oe[r]  = m_oe;
                end
                if (r == 0) e0 = edges;
                if (r == 1) e1 = edges;
                if (r >= p) wf = {wf[30:0], m_out};
                if (r == p + RD_SPLIT - 1) begin
                    widx = wf[11:2];
                    phy_word = (wf[13:12] == OP_READ) ? phy_regs[widx]
                                                      : 16'($urandom);
                end
                n = r + 1;
                if (n >= p + RD_SPLIT && n < p + FRAME_BITS)
                    mdio_in = phy_word[15 - (n - p - RD_SPLIT)];
                else
                    mdio_in = 1'($urandom);
                rises++;
                if (abort_at >= 0 && r == p + abort_at) begin
                    reset = 1'b1;
                    #1;
                    chk("abort_lines",
                        {m_mdc, m_out, m_oe, m_rdy, m_busy, m_rd}, '0);
                    aborted = 1'b1;
                    done = 1'b1;
                end
            end
            prev_mdc = m_mdc;
            if (!done && !m_busy) done = 1'b1;
            if (!done && edges > explat + 40) begin
                chk("timeout", edges, explat);
                aborted = 1'b1;
                done = 1'b1;
            end
        end
        tv0 = 1'b0;
        tv1 = 1'b0;
        if (!aborted) begin
            chk("latency", edges, explat);
            chk("mdc_rises", rises, p + FRAME_BITS);
            chk("wire_out", obs_out, exp_out);
            chk("wire_oe", obs_oe, exp_oe);
            chk("mdc_period", e1 - e0, 2 * cd);
            chk("rdy_pulses", rdy_cnt, rd_op ? 1 : 0);
            if (rd_op) begin
                chk("rd_data", rd_at, exp_rd);
                rd_last[u] = exp_rd;
            end
            if (frame[OP_HI:OP_LO] == OP_WRITE)
                ref_regs[idx] = frame[DAT_HI:DAT_LO];
            if (rises == p + FRAME_BITS && wf[29:28] == OP_WRITE &&
                wf[31:30] == ST)
                phy_regs[wf[27:18]] = wf[15:0];
            repeat (3) @(posedge clk);
            #1;
            chk("rd_hold", m_rd, rd_last[u]);
            chk("idle_lines", {m_mdc, m_oe, m_busy, m_rdy}, '0);
        end
    endtask

    function automatic logic [31:0] rand_frame();
        logic [1:0]  op;
        logic [4:0]  phy, rg;
        logic [1:0]  ta;
        logic [15:0] dat;
        int          k;
        k = $urandom_range(0, 9);
        op  = (k < 4) ? OP_WRITE : ((k < 8) ? OP_READ : ((k == 8) ? 2'b00 : 2'b11));
        phy = 5'($urandom_range(0, 1));
        rg  = 5'($urandom_range(0, 3));
        ta  = 2'($urandom);
        dat = 16'($urandom);
        return {ST, op, phy, rg, ta, dat};
    endfunction

    initial begin
        logic [31:0] f;
        logic [15:0] w;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        tv0 = 1'b0; tv1 = 1'b0;
        t_data = '0;
        mdio_in = 1'b0;
        sel = 0;
        rd_last[0] = '0;
        rd_last[1] = '0;
        for (int i = 0; i < 1024; i++) begin
            w = 16'($urandom);
            ref_regs[i] = w;
            phy_regs[i] = w;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            sel = u;
            #1;
            chk("reset_lines",
                {m_mdc, m_out, m_oe, m_rdy, m_busy, m_rd}, '0);
        end
        @(negedge clk);
        reset = 1'b0;

        run_frame(0, 32'h5086_ABCD, 0, -1);

        f = 32'h6086_0000;
        ref_regs[f[PHY_HI:REG_LO]] = 16'hBEEF;
        phy_regs[f[PHY_HI:REG_LO]] = 16'hBEEF;
        run_frame(0, f, 0, -1);

        run_frame(0, 32'h5086_1111, 1, -1);
        run_frame(0, 32'h6086_0000, 2, -1);

        run_frame(0, 32'h6086_0000, 0, 20);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rd_last[0] = '0;
        rd_last[1] = '0;
        sel = 0;
        #1;
        chk("rd_after_abort", m_rd, rd_last[0]);
        run_frame(0, 32'h6086_0000, 0, -1);

        run_frame(1, 32'h5FFF_0001, 0, -1);
        run_frame(1, 32'h6FFF_0000, 1, -1);

        for (int t = 0; t < 40; t++) begin
            run_frame($urandom_range(0, 1), rand_frame(),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                      -1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
